// File: rtl/bridge_pkg.sv
// bridge_pkg: shared constants and types for the io_bridge_n CPU-to-peripheral bridge.
package bridge_pkg;
    localparam int IC_IPEND   = 0;
    localparam int IC_IMASK   = 1;
    localparam int IC_ICAUSE  = 2;
    localparam int IC_BADADDR = 3;
    localparam int IC_ISTAT   = 4;
    localparam int ISTAT_ERR  = 0;
    localparam int ISTAT_OVF  = 1;
    // Largest device count any instance may use (NUM_DEV <= INT_W); the IC is slot NUM_DEV.
    localparam int MAX_DEV = 63;
    typedef logic [$clog2(MAX_DEV+1)-1:0] slot_t;
endpackage

// File: rtl/int_ctrl.sv
// int_ctrl: interrupt controller (edge/level capture, pending/mask/cause) plus bus-error capture.
module int_ctrl
    import bridge_pkg::*;
#(
    parameter int NUM_DEV = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int WIN_BITS = 4,
    parameter int INT_W = 6,
    parameter logic [NUM_DEV-1:0] EDGE_MASK = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_DEV-1:0]  dev_irq_i,
    input  logic                sel_i,
    input  logic                we_i,
    input  logic                re_i,
    input  logic [WIN_BITS-1:0] addr_i,
    input  logic [NUM_DEV-1:0]  wd_i,
    input  logic [NUM_DEV-1:0]  wmask_i,
    input  logic                bad_i,
    input  logic [ADDR_W-1:0]   bad_addr_i,
    output logic [DATA_W-1:0]   rd_o,
    output logic [INT_W-1:0]    hw_int_o
);
    logic [NUM_DEV-1:0] irq_q, irq_qq, ipend_q, ipend_d, imask_q, imask_d, act, clr;
    logic [ADDR_W-1:0]  badaddr_q, badaddr_d;
    logic               err_q, err_d, ovf_q, ovf_d;
    logic [7:0]         idx;
    logic [DATA_W-1:0]  cause, istat;

    assign act = ipend_q & imask_q;

    always_comb begin
        idx = '0;
        for (int i = NUM_DEV - 1; i >= 0; i--)
            if (act[i]) idx = 8'(i);
    end

    always_comb begin
        clr       = (sel_i & we_i & addr_i == WIN_BITS'(IC_IPEND)) ? wd_i & wmask_i & EDGE_MASK : '0;
        // An edge detected this cycle beats a simultaneous write-1-to-clear.
        ipend_d   = (EDGE_MASK & ((ipend_q & ~clr) | (irq_q & ~irq_qq))) | (~EDGE_MASK & irq_q);
        imask_d   = (sel_i & we_i & addr_i == WIN_BITS'(IC_IMASK)) ? (imask_q & ~wmask_i) | (wd_i & wmask_i) : imask_q;
        badaddr_d = bad_i ? bad_addr_i : badaddr_q;
        err_d     = bad_i | (err_q & ~(sel_i & re_i & addr_i == WIN_BITS'(IC_BADADDR)));
        ovf_d     = ovf_q | (bad_i & err_q);
        cause     = '0;
        cause[31] = |act;
        cause[7:0] = idx;
        istat     = '0;
        istat[ISTAT_ERR] = err_q;
        istat[ISTAT_OVF] = ovf_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q     <= '0;
            irq_qq    <= '0;
            ipend_q   <= '0;
            imask_q   <= '0;
            badaddr_q <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            irq_q     <= dev_irq_i;
            irq_qq    <= irq_q;
            ipend_q   <= ipend_d;
            imask_q   <= imask_d;
            badaddr_q <= badaddr_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
        end
    end

    assign rd_o = addr_i == WIN_BITS'(IC_IPEND)   ? DATA_W'(ipend_q) :
                  addr_i == WIN_BITS'(IC_IMASK)   ? DATA_W'(imask_q) :
                  addr_i == WIN_BITS'(IC_ICAUSE)  ? cause :
                  addr_i == WIN_BITS'(IC_BADADDR) ? DATA_W'(badaddr_q) :
                  addr_i == WIN_BITS'(IC_ISTAT)   ? istat : '0;

    assign hw_int_o = INT_W'(act);
endmodule

// File: rtl/io_bridge_n.sv
// io_bridge_n: decodes core I/O accesses onto NUM_DEV device windows plus an interrupt
// controller window, muxes read data and stalls the core on not-ready devices.
module io_bridge_n
    import bridge_pkg::*;
#(
    parameter int NUM_DEV = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int WIN_BITS = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h0000_7F00,
    parameter int INT_W = 6,
    parameter logic [NUM_DEV-1:0] EDGE_MASK = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         pr_addr,
    input  logic [DATA_W-1:0]         pr_wd,
    input  logic [DATA_W/8-1:0]       pr_be,
    input  logic                      io_write,
    input  logic                      io_read,
    output logic [DATA_W-1:0]         pr_rd,
    output logic                      pr_stall,
    output logic [WIN_BITS-1:0]       dev_addr,
    output logic [DATA_W-1:0]         dev_wd,
    output logic [DATA_W/8-1:0]       dev_be,
    output logic [NUM_DEV-1:0]        dev_we,
    output logic [NUM_DEV-1:0]        dev_re,
    input  logic [NUM_DEV*DATA_W-1:0] dev_rd,
    input  logic [NUM_DEV-1:0]        dev_ready,
    input  logic [NUM_DEV-1:0]        dev_irq,
    output logic [INT_W-1:0]          hw_int
);
    logic [ADDR_W-1:0]  slot_full;
    slot_t              slot;
    logic               req, is_dev, is_ic;
    logic [NUM_DEV-1:0] sel, bmask;
    logic [DATA_W-1:0]  ic_rd;

    // Addresses below BASE_ADDR wrap to a huge slot number and fall out as unmapped.
    assign slot_full = (pr_addr - BASE_ADDR) >> (WIN_BITS + 2);
    assign slot      = slot_t'(slot_full);
    assign is_dev    = slot_full < ADDR_W'(NUM_DEV);
    assign is_ic     = slot_full == ADDR_W'(NUM_DEV);
    assign req       = io_write | io_read;
    assign sel       = is_dev ? NUM_DEV'(1) << slot : '0;

    assign dev_we   = {NUM_DEV{io_write}} & sel & dev_ready;
    assign dev_re   = {NUM_DEV{io_read & ~io_write}} & sel;
    assign pr_stall = req & |(sel & ~dev_ready);
    assign dev_addr = pr_addr[WIN_BITS+1:2];
    assign dev_wd   = pr_wd;
    assign dev_be   = pr_be;
    assign pr_rd    = !req ? '0 : is_dev ? dev_rd[slot*DATA_W +: DATA_W] : is_ic ? ic_rd : '0;

    for (genvar b = 0; b < NUM_DEV; b++) begin : g_bm
        assign bmask[b] = pr_be[b/8];
    end

    int_ctrl #(
        .NUM_DEV(NUM_DEV), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .WIN_BITS(WIN_BITS), .INT_W(INT_W), .EDGE_MASK(EDGE_MASK)
    ) u_ic (
        .clk(clk),
        .rst(rst),
        .dev_irq_i(dev_irq),
        .sel_i(is_ic),
        .we_i(io_write),
        .re_i(io_read & ~io_write),
        .addr_i(pr_addr[WIN_BITS+1:2]),
        .wd_i(pr_wd[NUM_DEV-1:0]),
        .wmask_i(bmask),
        .bad_i(req & ~is_dev & ~is_ic),
        .bad_addr_i(pr_addr),
        .rd_o(ic_rd),
        .hw_int_o(hw_int)
    );
endmodule

// File: tb/tb_io_bridge_n.sv
// tb_io_bridge_n: directed plus random stimulus against a behavioural model of the bridge.
module tb_io_bridge_n;
    localparam logic [31:0] BASE = 32'h0000_7F00;
    localparam logic [31:0] IC   = 32'h0000_8000;
    localparam logic [3:0]  EM   = 4'b0001;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  pr_addr = '0, pr_wd = '0, pr_rd, dev_wd;
    logic [3:0]   pr_be = '0, dev_be, dev_we, dev_re, dev_ready = 4'hF, dev_irq = '0;
    logic         io_write = 1'b0, io_read = 1'b0, pr_stall;
    logic [3:0]   dev_addr;
    logic [127:0] dev_rd = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
    logic [5:0]   hw_int;

    int vec = 0, bad = 0;

    logic [3:0]  m_q, m_qq, m_pend, m_mask;
    logic [31:0] m_bad;
    logic        m_err, m_ovf;

    io_bridge_n #(.EDGE_MASK(EM)) dut (
        .clk(clk), .rst(rst), .pr_addr(pr_addr), .pr_wd(pr_wd), .pr_be(pr_be),
        .io_write(io_write), .io_read(io_read), .pr_rd(pr_rd), .pr_stall(pr_stall),
        .dev_addr(dev_addr), .dev_wd(dev_wd), .dev_be(dev_be), .dev_we(dev_we),
        .dev_re(dev_re), .dev_rd(dev_rd), .dev_ready(dev_ready), .dev_irq(dev_irq),
        .hw_int(hw_int)
    );

    always #5 clk = ~clk;

    function automatic int slot_of(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return int'(o / 64);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return int'((o % 64) / 4);
    endfunction

    function automatic logic [31:0] exp_cause();
        logic [3:0] a;
        a = m_pend & m_mask;
        for (int i = 0; i < 4; i++)
            if (a[i]) return 32'h8000_0000 + i;
        return 0;
    endfunction

    function automatic logic [31:0] exp_rd();
        int s;
        s = slot_of(pr_addr);
        if (!(io_write || io_read)) return 0;
        if (s < 4) return dev_rd[s*32 +: 32];
        if (s > 4) return 0;
        case (word_of(pr_addr))
            0: return {28'b0, m_pend};
            1: return {28'b0, m_mask};
            2: return exp_cause();
            3: return m_bad;
            4: return {30'b0, m_ovf, m_err};
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] next_pend();
        logic [3:0] n;
        logic       wc;
        wc = io_write && slot_of(pr_addr) == 4 && word_of(pr_addr) == 0 && pr_be[0];
        for (int i = 0; i < 4; i++)
            n[i] = EM[i] ? ((m_pend[i] && !(wc && pr_wd[i])) || (m_q[i] && !m_qq[i])) : m_q[i];
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q <= '0; m_qq <= '0; m_pend <= '0; m_mask <= '0;
            m_bad <= '0; m_err <= 1'b0; m_ovf <= 1'b0;
        end else begin
            m_q    <= dev_irq;
            m_qq   <= m_q;
            m_pend <= next_pend();
            if (io_write && slot_of(pr_addr) == 4 && word_of(pr_addr) == 1 && pr_be[0])
                m_mask <= pr_wd[3:0];
            if ((io_write || io_read) && slot_of(pr_addr) > 4) begin
                m_bad <= pr_addr;
                m_err <= 1'b1;
                if (m_err) m_ovf <= 1'b1;
            end else if (io_read && !io_write && slot_of(pr_addr) == 4 && word_of(pr_addr) == 3)
                m_err <= 1'b0;
        end
    end

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", n, got, exp);
        end
    endtask

    always @(negedge clk) begin
        int s;
        logic [3:0] oh;
        s  = slot_of(pr_addr);
        oh = (s < 4) ? 4'(1 << s) : 4'b0;
        chk("pr_rd", pr_rd, exp_rd());
        chk("dev_we", 32'(dev_we), io_write ? 32'(oh & dev_ready) : 0);
        chk("dev_re", 32'(dev_re), (io_read && !io_write) ? 32'(oh) : 0);
        chk("pr_stall", 32'(pr_stall), 32'((io_write || io_read) && s < 4 && !dev_ready[s % 4]));
        chk("dev_addr", 32'(dev_addr), (pr_addr >> 2) % 16);
        chk("dev_wd", dev_wd, pr_wd);
        chk("dev_be", 32'(dev_be), 32'(pr_be));
        chk("hw_int", 32'(hw_int), 32'(m_pend & m_mask));
    end

    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic w, input logic r);
        @(posedge clk);
        #1;
        pr_addr = a; pr_wd = d; pr_be = be; io_write = w; io_read = r;
        @(negedge clk);
        #1;
    endtask

    task automatic set_irq(input logic [3:0] v);
        @(posedge clk);
        #1;
        dev_irq = v; io_write = 1'b0; io_read = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        @(negedge clk);
        #1;
        chk("reset_hw_int", 32'(hw_int), 0);
        rst = 1'b0;
        cyc(BASE + 32'h44, 32'hDEAD_BEEF, 4'b0011, 1, 0);
        chk("wr_we", 32'(dev_we), 32'b0010);
        chk("wr_addr", 32'(dev_addr), 1);
        chk("wr_be", 32'(dev_be), 32'b0011);
        chk("wr_stall", 32'(pr_stall), 0);
        dev_ready = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            cyc(BASE + 32'h80, 0, 4'hF, 0, 1);
            chk("rd_stall", 32'(pr_stall), 1);
            chk("rd_re", 32'(dev_re), 32'b0100);
        end
        dev_ready = 4'hF;
        cyc(BASE + 32'h80, 0, 4'hF, 0, 1);
        chk("rd_release", 32'(pr_stall), 0);
        chk("rd_data", pr_rd, 32'hC0DE_0002);
        cyc(IC + 4, 1, 4'hF, 1, 0);
        set_irq(4'b0001);
        set_irq(4'b0000);
        cyc(0, 0, 0, 0, 0);
        chk("edge_hw_int", 32'(hw_int), 32'b000001);
        cyc(IC + 8, 0, 4'hF, 0, 1);
        chk("edge_cause", pr_rd, 32'h8000_0000);
        cyc(IC, 1, 4'hF, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk("w1c_hw_int", 32'(hw_int), 0);
        cyc(IC + 4, 32'hA, 4'hF, 1, 0);
        set_irq(4'b1010);
        cyc(0, 0, 0, 0, 0);
        cyc(IC + 8, 0, 4'hF, 0, 1);
        chk("lvl_cause", pr_rd, 32'h8000_0001);
        cyc(IC, 32'hF, 4'hF, 1, 0);
        cyc(IC, 0, 4'hF, 0, 1);
        chk("lvl_ipend", pr_rd, 32'hA);
        set_irq(4'b1000);
        cyc(IC + 8, 0, 4'hF, 0, 1);
        chk("lvl_cause_lag", pr_rd, 32'h8000_0001);
        cyc(IC + 8, 0, 4'hF, 0, 1);
        chk("lvl_cause_drop", pr_rd, 32'h8000_0003);
        set_irq(4'b0000);
        cyc(32'h4, 0, 4'hF, 0, 1);
        chk("unmap_rd", pr_rd, 0);
        cyc(IC + 16, 0, 4'hF, 0, 1);
        chk("istat_err", pr_rd, 1);
        cyc(32'h10, 0, 4'hF, 1, 0);
        cyc(IC + 16, 0, 4'hF, 0, 1);
        chk("istat_ovf", pr_rd, 3);
        cyc(IC + 12, 0, 4'hF, 0, 1);
        chk("badaddr", pr_rd, 32'h10);
        cyc(IC + 16, 0, 4'hF, 0, 1);
        chk("istat_clr", pr_rd, 2);
        cyc(IC + 4, 32'hF, 4'hF, 1, 0);
        set_irq(4'b0101);
        cyc(0, 0, 0, 0, 0);
        cyc(IC, 0, 4'hF, 0, 1);
        chk("pre_rst_ipend", pr_rd, 5);
        chk("pre_rst_hw_int", 32'(hw_int), 5);
        set_irq(4'b0000);
        @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        chk("rst_hw_int", 32'(hw_int), 0);
        #1 rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc(IC + 32'(k * 4), 0, 4'hF, 0, 1);
            chk("post_rst_reg", pr_rd, 0);
        end
        for (int n = 0; n < 3000; n++) begin
            int kind, op;
            @(posedge clk);
            #1;
            kind = $urandom_range(0, 9);
            op   = $urandom_range(0, 15);
            pr_addr = kind < 5  ? BASE + 32'($urandom_range(0, 3) * 64 + $urandom_range(0, 63)) :
                      kind < 7  ? IC + 32'($urandom_range(0, 6) * 4 + $urandom_range(0, 3)) :
                      kind == 7 ? 32'($urandom_range(0, 32'h7EFF)) :
                      kind == 8 ? BASE + 32'h140 + 32'($urandom_range(0, 4095)) : $urandom;
            pr_wd    = $urandom;
            pr_be    = 4'($urandom);
            io_read  = op < 6 || op == 12;
            io_write = (op >= 6 && op <= 12);
            dev_ready = 4'($urandom);
            dev_rd    = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 3) == 0) dev_irq = 4'($urandom);
            rst = ($urandom_range(0, 499) == 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
